// File: rtl/pipe_adder_pkg.sv
// Shared defaults and the per-stage control payload for pipe_adder.
// PIPE_ADDER_SUB_EN adds a per-beat subtract flag to the payload.
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Control half of a stage payload; the data half (partial sum, upper
  // operand segments) is sized by the instantiating module's WIDTH.
  typedef struct packed {
    logic vld;
    logic cy;
`ifdef PIPE_ADDER_SUB_EN
    logic sub;
`endif
  } pl_ctrl_t;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline slice: SEG-bit ripple add of segment K plus payload register
// and valid/ready handshake. PIPE_ADDER_SUB_EN adds per-beat B inversion.
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = seg_width(DEF_WIDTH, DEF_STAGES),
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  pl_ctrl_t         up_ctl,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_sum,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  output pl_ctrl_t         dn_ctl,
  input  logic             dn_rdy,
  output logic [WIDTH-1:0] dn_sum,
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b
);

  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (K * SEG);

  logic [SEG-1:0]   seg_a, seg_b, seg_s;
  logic             seg_c;
  logic [WIDTH-1:0] sum_n;
  pl_ctrl_t         ctl_q;
  logic [WIDTH-1:0] sum_q, a_q, b_q;

  always_comb begin
    seg_a = up_a[K*SEG +: SEG];
    seg_b = up_b[K*SEG +: SEG];
`ifdef PIPE_ADDER_SUB_EN
    seg_b = seg_b ^ {SEG{up_ctl.sub}};
`endif
    seg_c = up_ctl.cy;
    seg_s = '0;
    for (int i = 0; i < SEG; i++) begin
      seg_s[i] = seg_a[i] ^ seg_b[i] ^ seg_c;
      seg_c    = (seg_a[i] & seg_b[i]) | (seg_c & (seg_a[i] ^ seg_b[i]));
    end
    sum_n = up_sum;
    sum_n[K*SEG +: SEG] = seg_s;
  end

  // Bubbles collapse: an empty slot accepts regardless of downstream.
  assign up_rdy = !ctl_q.vld || dn_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= '0;
      sum_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (up_rdy) begin
      ctl_q.vld <= up_ctl.vld;
      if (up_ctl.vld) begin
        ctl_q.cy  <= seg_c;
`ifdef PIPE_ADDER_SUB_EN
        ctl_q.sub <= up_ctl.sub;
`endif
        sum_q <= sum_n;
        // Consumed segments are dropped; only upper segments travel on.
        a_q   <= up_a & ~SEG_MASK;
        b_q   <= up_b & ~SEG_MASK;
      end
    end
  end

  assign dn_ctl = ctl_q;
  assign dn_sum = sum_q;
  assign dn_a   = a_q;
  assign dn_b   = b_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder, one SEG-bit carry segment per stage, with a
// valid/ready stream on both sides. PIPE_ADDER_SUB_EN enables sub_i.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  pl_ctrl_t [STAGES:0]            ctl;
  logic     [STAGES:0]            rdy;
  logic     [STAGES:0][WIDTH-1:0] sum, opa, opb;

  // Subtract is a + ~b + !c, so the borrow-in enters stage 0 inverted.
`ifdef PIPE_ADDER_SUB_EN
  assign ctl[0] = '{vld: in_valid_i, cy: c_i ^ sub_i, sub: sub_i};
`else
  assign ctl[0] = '{vld: in_valid_i, cy: c_i};
`endif
  assign sum[0]      = '0;
  assign opa[0]      = a_i;
  assign opb[0]      = b_i;
  assign rdy[STAGES] = out_ready_i;
  assign in_ready_o  = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_stage #(.WIDTH(WIDTH), .SEG(SEG), .K(k)) u_stage (
      .clk    (clk_i),
      .rst_n  (rst_n_i),
      .up_ctl (ctl[k]),
      .up_rdy (rdy[k]),
      .up_sum (sum[k]),
      .up_a   (opa[k]),
      .up_b   (opb[k]),
      .dn_ctl (ctl[k+1]),
      .dn_rdy (rdy[k+1]),
      .dn_sum (sum[k+1]),
      .dn_a   (opa[k+1]),
      .dn_b   (opb[k+1])
    );
  end

  assign out_valid_o = ctl[STAGES].vld;
  assign carry_o     = ctl[STAGES].cy;
  assign sum_o       = sum[STAGES];

endmodule

// File: tb/tb_pipe_adder.sv
// Directed-vector bench for pipe_adder (WIDTH=16, STAGES=4) with an
// in-order scoreboard; subtract vectors appear with PIPE_ADDER_SUB_EN.
module tb_pipe_adder;

  localparam int ST = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, c, carry;
  logic [15:0] a, b, sum;
`ifdef PIPE_ADDER_SUB_EN
  logic        sub;
`endif

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(16), .STAGES(ST)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .c_i         (c),
`ifdef PIPE_ADDER_SUB_EN
    .sub_i       (sub),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .carry_o     (carry)
  );

  typedef struct {
    logic [15:0] a, b;
    logic        c, s;
    logic [15:0] es;
    logic        ecy;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cy;
    int          win;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_cmp = 0, n_err = 0, win = 0, acc_cnt = 0, spurious = 0;
  bit   lat_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (window %0d)", nm, act, exp, win);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] x, y, input logic ci, s);
    if (s) return {1'b0, x} + {1'b0, ~y} + {16'd0, ~ci};
    return {1'b0, x} + {1'b0, y} + {16'd0, ci};
  endfunction

  // One clock window: drive, observe handshakes, advance to just after the edge.
  task automatic cycle(input logic iv, input logic [15:0] ia, ib, input logic ic, isub,
                       input logic ordy, input logic [15:0] es, input logic ecy);
    exp_t e;
    in_valid = iv; a = ia; b = ib; c = ic; out_ready = ordy;
`ifdef PIPE_ADDER_SUB_EN
    sub = isub;
`endif
    #1;
    if (iv && in_ready) begin
      sb.push_back('{sum: es, cy: ecy, win: win});
      acc_cnt++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) spurious++;
      else begin
        e = sb.pop_front();
        chk("result", {15'd0, carry, sum}, {15'd0, e.cy, e.sum});
        if (lat_chk) chk("latency", win - e.win, ST);
      end
    end
    @(posedge clk); #1;
    win++;
  endtask

  task automatic rand_cycle(input logic iv, input logic ordy);
    logic [15:0] x, y;
    logic        ci, s;
    logic [16:0] r;
    x  = 16'($urandom);
    y  = 16'($urandom);
    ci = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
    s  = 1'($urandom);
`else
    s  = 1'b0;
`endif
    r = model(x, y, ci, s);
    cycle(iv, x, y, ci, s, ordy, r[15:0], r[16]);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0);
    chk("drain_empty", sb.size(), 0);
    chk("spurious", spurious, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; in_valid = 1; a = 16'hFFFF; b = 16'hFFFF; c = 1; out_ready = 0;
`ifdef PIPE_ADDER_SUB_EN
    sub = 0;
`endif
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1});
    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
    vecs.push_back('{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0});
`ifdef PIPE_ADDER_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h1000, 16'h0001, 1'b0, 1'b0, 16'h1001, 1'b0});
    vecs.push_back('{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFE, 1'b1});
`endif

    // Reset state with in_valid held high: nothing may be captured.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_in_ready", in_ready, 1);
    in_valid = 0;
    rst_n = 1;
    @(posedge clk); #1;

    // Table vectors back to back, unstalled: in order at latency STAGES.
    lat_chk = 1;
    foreach (vecs[i]) cycle(1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, 1, vecs[i].es, vecs[i].ecy);
    drain();

    // Eight random back-to-back beats.
    repeat (8) rand_cycle(1, 1);
    drain();
    lat_chk = 0;

    // Full pipe: out_ready low for 10 cycles admits exactly STAGES beats.
    acc_cnt = 0;
    repeat (10) rand_cycle(1, 0);
    chk("full_accepts", acc_cnt, ST);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    out_ready = 1;
    #1;
    chk("shift_in_ready", in_ready, 1);
    rand_cycle(1, 1);
    drain();

    // Random valid and backpressure with scoreboard.
    repeat (60) rand_cycle(1'($urandom), 1'($urandom));
    drain();

    // Reset with three beats in flight discards them.
    repeat (3) rand_cycle(1, 1);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sum", sum, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1;
    repeat (8) cycle(0, 0, 0, 0, 0, 1, 0, 0);
    chk("no_stale", spurious, 0);
    lat_chk = 1;
    cycle(1, 16'h0001, 16'h0002, 0, 0, 1, 16'h0003, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
